// File: rtl/status_collector_pkg.sv
// status_collector_pkg: shared RAM map constants and scan FSM encoding
package status_collector_pkg;
  localparam int WORD_W    = 32;
  localparam int RAM_DEPTH = 256;
  localparam logic [7:0] CMD0_BASE = 8'd0;
  localparam logic [7:0] CMD1_BASE = 8'd32;
  localparam logic [7:0] STAT_BASE = 8'd128;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_e;
endpackage

// File: rtl/status_dpram.sv
// status_dpram: 256x32 write / 128x64 read simple dual-port RAM, 2-cycle registered read
module status_dpram
  import status_collector_pkg::*;
(
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [7:0]        waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              rd_en_i,
  input  logic [6:0]        raddr_i,
  output logic [63:0]       rdata_o,
  output logic              rvld_o
);
  logic [WORD_W-1:0] even_q [RAM_DEPTH/2];
  logic [WORD_W-1:0] odd_q  [RAM_DEPTH/2];
  logic [63:0] rd1_q, rdata_q;
  logic        vld1_q, rvld_q;
  // even words form the upper half of a readback word, odd words the lower half
  always_ff @(posedge sys_clk) begin
    if (we_i && !waddr_i[0]) even_q[waddr_i[7:1]] <= wdata_i;
    if (we_i && waddr_i[0]) odd_q[waddr_i[7:1]] <= wdata_i;
  end
  // two-stage read pipe; a same-cycle write is not visible to the read
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q   <= '0;
      rdata_q <= '0;
      vld1_q  <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      rd1_q   <= rd_en_i ? {even_q[raddr_i], odd_q[raddr_i]} : rd1_q;
      rdata_q <= rd1_q;
      vld1_q  <= rd_en_i;
      rvld_q  <= vld1_q;
    end
  end
  assign rdata_o = rdata_q;
  assign rvld_o  = rvld_q;
endmodule

// File: rtl/status_collector.sv
// status_collector: command mirrors and periodic status snapshot into a shared RAM (option: STATUS_CHANGE_IRQ_EN)
module status_collector
  import status_collector_pkg::*;
#(
  parameter int NUM_STATUS    = 9,
  parameter int PERIOD_CYCLES = 12500
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic [63:0]                cmd0_data,
  input  logic [3:0]                 cmd0_addr,
  input  logic                       cmd0_en,
  input  logic [127:0]               cmd1_data,
  input  logic [2:0]                 cmd1_addr,
  input  logic                       cmd1_en,
  input  logic [32*NUM_STATUS-1:0]   status_bus,
  output logic                       updating_status,
  output logic                       scan_done,
  output logic [1:0]                 cmd_overflow,
  input  logic [6:0]                 status_rd_addr,
  input  logic                       status_rd_en,
  output logic [63:0]                status_rd_data,
  output logic                       status_rd_vld
`ifdef STATUS_CHANGE_IRQ_EN
  ,
  output logic                       status_irq,
  output logic [NUM_STATUS-1:0]      status_chg_mask
`endif
);
  localparam int PW  = $clog2(PERIOD_CYCLES);
  localparam int SW  = $clog2(NUM_STATUS + 2);
  localparam int PAD = (1 << SW) - NUM_STATUS - 1;
  logic [PW-1:0]             cnt_q;
  logic [31:0]               hb_q;
  logic [32*NUM_STATUS-1:0]  shadow_q;
  logic                      upd_q, en0_q, en1_q, p0_q, p1_q, w0_q;
  logic [1:0]                w1_q, ovf_q;
  logic [3:0]                a0_q;
  logic [2:0]                a1_q;
  logic [63:0]               d0_q;
  logic [127:0]              d1_q;
  scan_state_e               state_q, state_d;
  logic [SW-1:0]             idx_q, idx_d;
  logic [32*(1<<SW)-1:0]     scan_vec;
  logic tick, rise0, rise1, g0, g1, gs, last, we;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  assign tick     = cnt_q == '0;
  assign rise0    = cmd0_en & ~en0_q;
  assign rise1    = cmd1_en & ~en1_q;
  assign g0       = p0_q;
  assign g1       = p1_q & ~p0_q;
  assign gs       = (state_q == SCAN) & ~p0_q & ~p1_q;
  assign last     = idx_q == SW'(NUM_STATUS);
  assign scan_vec = {{(32*PAD){1'b0}}, shadow_q, hb_q};
  assign we       = g0 | g1 | gs;
  assign waddr    = g0 ? CMD0_BASE + {3'b0, a0_q, w0_q} :
                    g1 ? CMD1_BASE + {3'b0, a1_q, w1_q} : STAT_BASE + 8'(idx_q);
  assign wdata    = g0 ? (w0_q ? d0_q[63:32] : d0_q[31:0]) :
                    g1 ? d1_q[{w1_q, 5'b0} +: 32] : scan_vec[{idx_q, 5'b0} +: 32];
  // period counter; count 0 bumps the heartbeat and samples every channel at once
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      hb_q     <= '0;
      shadow_q <= '0;
      upd_q    <= 1'b0;
    end else begin
      cnt_q <= (cnt_q == PW'(PERIOD_CYCLES - 1)) ? '0 : cnt_q + PW'(1);
      upd_q <= tick;
      if (tick) begin
        hb_q     <= hb_q + 32'd1;
        shadow_q <= status_bus;
      end
    end
  end
  // command edge capture and word sequencing; an edge while pending is dropped and flagged
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      en0_q <= 1'b0;
      en1_q <= 1'b0;
      p0_q  <= 1'b0;
      p1_q  <= 1'b0;
      w0_q  <= 1'b0;
      w1_q  <= '0;
      a0_q  <= '0;
      a1_q  <= '0;
      d0_q  <= '0;
      d1_q  <= '0;
      ovf_q <= '0;
    end else begin
      en0_q <= cmd0_en;
      en1_q <= cmd1_en;
      ovf_q <= ovf_q | {rise1 & p1_q, rise0 & p0_q};
      if (rise0 && !p0_q) begin
        p0_q <= 1'b1;
        w0_q <= 1'b0;
        a0_q <= cmd0_addr;
        d0_q <= cmd0_data;
      end else if (g0) begin
        p0_q <= ~w0_q;
        w0_q <= ~w0_q;
      end
      if (rise1 && !p1_q) begin
        p1_q <= 1'b1;
        w1_q <= '0;
        a1_q <= cmd1_addr;
        d1_q <= cmd1_data;
      end else if (g1) begin
        p1_q <= w1_q != 2'd3;
        w1_q <= w1_q + 2'd1;
      end
    end
  end
  // scan FSM state register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end
  // scan next state; a tick always restarts from the heartbeat word
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (tick) begin
      state_d = SCAN;
      idx_d   = '0;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (gs) begin
      state_d = last ? DONE : SCAN;
      idx_d   = idx_q + SW'(1);
    end
  end
  assign updating_status = upd_q;
  assign scan_done       = state_q == DONE;
  assign cmd_overflow    = ovf_q;
`ifdef STATUS_CHANGE_IRQ_EN
  logic [32*NUM_STATUS-1:0] prev_q;
  logic [NUM_STATUS-1:0]    mask_q, cmp;
  for (genvar k = 0; k < NUM_STATUS; k++) begin : g_cmp
    assign cmp[k] = shadow_q[32*k +: 32] != prev_q[32*k +: 32];
  end
  // the mask lands with the final scan write so it is stable during DONE
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      mask_q <= '0;
    end else if (gs && last) begin
      prev_q <= shadow_q;
      mask_q <= cmp;
    end
  end
  assign status_chg_mask = mask_q;
  assign status_irq      = scan_done & |mask_q;
`endif
  status_dpram u_ram (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .rd_en_i (status_rd_en),
    .raddr_i (status_rd_addr),
    .rdata_o (status_rd_data),
    .rvld_o  (status_rd_vld)
  );
endmodule

// File: tb/tb_status_collector.sv
// tb_status_collector: randomized directed bench against a word-level RAM model
module tb_status_collector;
  localparam int NS = 9;
  localparam int PC = 40;
  logic              sys_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [63:0]       cmd0_data = '0;
  logic [3:0]        cmd0_addr = '0;
  logic              cmd0_en = 1'b0;
  logic [127:0]      cmd1_data = '0;
  logic [2:0]        cmd1_addr = '0;
  logic              cmd1_en = 1'b0;
  logic [32*NS-1:0]  status_bus = '0;
  logic              updating_status, scan_done, status_rd_vld;
  logic [1:0]        cmd_overflow;
  logic [6:0]        status_rd_addr = '0;
  logic              status_rd_en = 1'b0;
  logic [63:0]       status_rd_data;
`ifdef STATUS_CHANGE_IRQ_EN
  logic              status_irq;
  logic [NS-1:0]     status_chg_mask;
`endif
  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  logic [31:0] mem_m [256];
  logic [31:0] snap [NS];
  logic [31:0] prev_m [NS];
  logic [NS-1:0] mask_m;

  always #5 sys_clk = ~sys_clk;

  status_collector #(.NUM_STATUS(NS), .PERIOD_CYCLES(PC)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .cmd0_data(cmd0_data), .cmd0_addr(cmd0_addr), .cmd0_en(cmd0_en),
    .cmd1_data(cmd1_data), .cmd1_addr(cmd1_addr), .cmd1_en(cmd1_en),
    .status_bus(status_bus), .updating_status(updating_status), .scan_done(scan_done),
    .cmd_overflow(cmd_overflow), .status_rd_addr(status_rd_addr), .status_rd_en(status_rd_en),
    .status_rd_data(status_rd_data), .status_rd_vld(status_rd_vld)
`ifdef STATUS_CHANGE_IRQ_EN
    , .status_irq(status_irq), .status_chg_mask(status_chg_mask)
`endif
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_snap();
    for (int k = 0; k < NS; k++) status_bus[32*k +: 32] = snap[k];
  endtask

  // heartbeat equals the number of period starts seen since reset release
  task automatic scan_model();
    mem_m[128] = 32'(cyc / PC + 1);
    for (int k = 0; k < NS; k++) begin
      mem_m[129+k] = snap[k];
      mask_m[k] = snap[k] != prev_m[k];
      prev_m[k] = snap[k];
    end
  endtask

  task automatic wait_done(input string tag, input int exp_n);
    int n = 0;
    while (scan_done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, 64'(scan_done), 64'd1);
    if (exp_n >= 0) chk({tag, "_lat"}, 64'(n), 64'(exp_n));
    scan_model();
`ifdef STATUS_CHANGE_IRQ_EN
    chk({tag, "_irq"}, 64'(status_irq), 64'(|mask_m));
    chk({tag, "_mask"}, 64'(status_chg_mask), 64'(mask_m));
`endif
    step();
    chk({tag, "_pulse"}, 64'(scan_done), 64'd0);
  endtask

  task automatic wait_upd();
    int n = 0;
    while (updating_status !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("upd_seen", 64'(updating_status), 64'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a);
    status_rd_addr = a;
    status_rd_en = 1'b1;
    step();
    status_rd_en = 1'b0;
    chk({tag, "_vld1"}, 64'(status_rd_vld), 64'd0);
    step();
    chk({tag, "_vld2"}, 64'(status_rd_vld), 64'd1);
    chk(tag, status_rd_data, {mem_m[{a, 1'b0}], mem_m[{a, 1'b1}]});
  endtask

  task automatic cmd0(input logic [3:0] a, input logic [63:0] d);
    cmd0_addr = a;
    cmd0_data = d;
    cmd0_en = 1'b1;
    step();
    cmd0_en = 1'b0;
    mem_m[2*a] = d[31:0];
    mem_m[2*a+1] = d[63:32];
    repeat (4) step();
  endtask

  task automatic cmd1(input logic [2:0] a, input logic [127:0] d);
    cmd1_addr = a;
    cmd1_data = d;
    cmd1_en = 1'b1;
    step();
    cmd1_en = 1'b0;
    for (int n = 0; n < 4; n++) mem_m[32+4*a+n] = d[32*n +: 32];
    repeat (4) step();
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
    cyc = 0;
    step();
    chk("upd_first", 64'(updating_status), 64'd1);
  endtask

  initial begin
    logic [3:0]   a0;
    logic [2:0]   a1;
    logic [63:0]  d0;
    logic [127:0] d1, d2;
    for (int k = 0; k < NS; k++) begin
      snap[k] = 32'hA000_0000 | 32'(k);
      prev_m[k] = '0;
    end
    apply_snap();
    repeat (3) step();
    chk("rst_upd", 64'(updating_status), 64'd0);
    chk("rst_done", 64'(scan_done), 64'd0);
    chk("rst_ovf", 64'(cmd_overflow), 64'd0);
    chk("rst_vld", 64'(status_rd_vld), 64'd0);
    chk("rst_data", status_rd_data, 64'd0);
    release_rst();
    wait_done("scan0", NS + 1);
    chk("hb_ch0_const", {mem_m[128], mem_m[129]}, 64'h0000_0001_A000_0000);
    rd_chk("hb_ch0", 7'd64);
    rd_chk("ch7_ch8", 7'd68);
    cmd0(4'd3, 64'h1111_2222_3333_4444);
    rd_chk("cmd0_a3", 7'd3);
    for (int p = 0; p < 6; p++) begin
      wait_done("scan_loop", -1);
      rd_chk("stat_rand", 7'($urandom_range(68, 64)));
      if (p == 3) snap[2] = snap[2] ^ 32'h0000_5A5A;
      else if (p < 3) for (int k = 0; k < NS; k++) snap[k] = $urandom;
      apply_snap();
      for (int t = 0; t < 2; t++) begin
        if ($urandom_range(1, 0) == 0) begin
          a0 = 4'($urandom_range(15, 0));
          cmd0(a0, {$urandom, $urandom});
          rd_chk("cmd0_rand", 7'(a0));
        end else begin
          a1 = 3'($urandom_range(7, 0));
          cmd1(a1, {$urandom, $urandom, $urandom, $urandom});
          rd_chk("cmd1_rand_lo", 7'(16 + 2*a1));
          rd_chk("cmd1_rand_hi", 7'(16 + 2*a1 + 1));
        end
      end
    end
    wait_upd();
    repeat (39) step();
    a0 = 4'($urandom_range(15, 0));
    a1 = 3'($urandom_range(7, 0));
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom, $urandom, $urandom};
    cmd0_addr = a0;
    cmd0_data = d0;
    cmd1_addr = a1;
    cmd1_data = d1;
    cmd0_en = 1'b1;
    cmd1_en = 1'b1;
    mem_m[2*a0] = d0[31:0];
    mem_m[2*a0+1] = d0[63:32];
    for (int n = 0; n < 4; n++) mem_m[32+4*a1+n] = d1[32*n +: 32];
    step();
    cmd0_en = 1'b0;
    cmd1_en = 1'b0;
    chk("upd_contend", 64'(updating_status), 64'd1);
    wait_done("scan_contend", 16);
    for (int w = 64; w <= 68; w++) rd_chk("stat_contend", 7'(w));
    rd_chk("cmd0_contend", 7'(a0));
    rd_chk("cmd1_contend_lo", 7'(16 + 2*a1));
    rd_chk("cmd1_contend_hi", 7'(16 + 2*a1 + 1));
    a1 = 3'd5;
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = ~d1;
    cmd1_addr = a1;
    cmd1_data = d1;
    cmd1_en = 1'b1;
    step();
    cmd1_en = 1'b0;
    step();
    cmd1_data = d2;
    cmd1_en = 1'b1;
    step();
    cmd1_en = 1'b0;
    for (int n = 0; n < 4; n++) mem_m[32+4*a1+n] = d1[32*n +: 32];
    repeat (4) step();
    chk("ovf_set", 64'(cmd_overflow), 64'd2);
    rd_chk("ovf_keep_lo", 7'(16 + 2*a1));
    rd_chk("ovf_keep_hi", 7'(16 + 2*a1 + 1));
    cmd1(a1, {$urandom, $urandom, $urandom, $urandom});
    rd_chk("ovf_after_lo", 7'(16 + 2*a1));
    rd_chk("ovf_after_hi", 7'(16 + 2*a1 + 1));
    chk("ovf_sticky", 64'(cmd_overflow), 64'd2);
    wait_upd();
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_upd", 64'(updating_status), 64'd0);
    chk("mid_rst_done", 64'(scan_done), 64'd0);
    chk("mid_rst_ovf", 64'(cmd_overflow), 64'd0);
    chk("mid_rst_vld", 64'(status_rd_vld), 64'd0);
    for (int k = 0; k < NS; k++) prev_m[k] = '0;
    repeat (2) step();
    release_rst();
    wait_done("scan_rst", NS + 1);
    rd_chk("hb_after_rst", 7'd64);
    rd_chk("stat_after_rst", 7'd68);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
